// File: rtl/column_stream_driver_pkg.sv
// Shared constants and types for column_stream_driver and its worksheet buffer.
package column_stream_driver_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam int RES_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_OP,
        EMIT_NUM,
        EMIT_DONE,
        WAIT_RES
    } state_t;

endpackage

// File: rtl/column_stream_driver_worksheet_buffer.sv
// Worksheet storage: number RAM, per-column operators, write counters and
// row-shape checking. Writes that overflow the array or break the shape flag load_err.
module worksheet_buffer
    import column_stream_driver_pkg::*;
#(
    parameter int MAX_ROWS = 8,
    parameter int MAX_COLS = 16,
    parameter int DW = 32,
    localparam int RW  = $clog2(MAX_ROWS + 1),
    localparam int CW  = $clog2(MAX_COLS + 1),
    localparam int RIW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
    localparam int CIW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_num,
    input  logic           wr_eol,
    input  logic           opw_en,
    input  logic           opw_op,
    input  logic [RIW-1:0] rd_row,
    input  logic [CIW-1:0] rd_col,
    output logic [DW-1:0]  rd_num,
    output logic           rd_op,
    output logic [RW-1:0]  rows,
    output logic [CW-1:0]  cols,
    output logic [CW-1:0]  op_cnt,
    output logic           load_err
);

    logic [DW-1:0]       mem_q [MAX_ROWS][MAX_COLS];
    logic [MAX_COLS-1:0] ops_q;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [CW-1:0] op_cnt_q, op_cnt_d;
    logic          mem_we;
    logic          op_we;

    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        cols_d   = cols_q;
        op_cnt_d = op_cnt_q;
        mem_we   = 1'b0;
        op_we    = 1'b0;
        load_err = 1'b0;
        if (clear) begin
            row_d    = '0;
            col_d    = '0;
            cols_d   = '0;
            op_cnt_d = '0;
        end else begin
            if (wr_en) begin
                if (row_q >= RW'(MAX_ROWS) || col_q >= CW'(MAX_COLS)) begin
                    load_err = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    if (wr_eol) begin
                        // The first closed row defines the worksheet width.
                        if (row_q == '0) begin
                            cols_d = col_q + 1'b1;
                        end else if (col_q + 1'b1 != cols_q) begin
                            load_err = 1'b1;
                        end
                        row_d = row_q + 1'b1;
                        col_d = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            if (opw_en) begin
                if (op_cnt_q >= CW'(MAX_COLS)) begin
                    load_err = 1'b1;
                end else begin
                    op_we    = 1'b1;
                    op_cnt_d = op_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            cols_q   <= '0;
            op_cnt_q <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            cols_q   <= cols_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Storage is left unreset; its contents are meaningless until reloaded.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[row_q[RIW-1:0]][col_q[CIW-1:0]] <= wr_num;
        end
        if (op_we) begin
            ops_q[op_cnt_q[CIW-1:0]] <= opw_op;
        end
    end

    assign rd_num = mem_q[rd_row][rd_col];
    assign rd_op  = ops_q[rd_col];
    assign rows   = row_q;
    assign cols   = cols_q;
    assign op_cnt = op_cnt_q;

endmodule

// File: rtl/column_stream_driver.sv
// Replays a buffered worksheet column by column to a reducer and sums the results.
// Optional COL_DRIVER_OVERLAP_EN merges the op strobe into the first number and overlaps columns.
module column_stream_driver
    import column_stream_driver_pkg::*;
#(
    parameter int MAX_ROWS = 8,
    parameter int MAX_COLS = 16,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_num,
    input  logic             wr_eol,
    input  logic             opw_valid,
    input  logic             opw_op,
    input  logic             start,
    output logic             num_valid,
    output logic [DW-1:0]    num_in,
    output logic             op_valid,
    output logic             op_in,
    output logic             done,
    input  logic             result_valid,
    input  logic [RES_W-1:0] result,
    output logic [RES_W-1:0] grand_total,
    output logic             busy,
    output logic             all_done,
    output logic             err
);

    localparam int RW  = $clog2(MAX_ROWS + 1);
    localparam int CW  = $clog2(MAX_COLS + 1);
    localparam int RIW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int CIW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

`ifdef COL_DRIVER_OVERLAP_EN
    localparam state_t FIRST_STATE = EMIT_NUM;
`else
    localparam state_t FIRST_STATE = EMIT_OP;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    col_idx_q, col_idx_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [RES_W-1:0] grand_total_q, grand_total_d;
    logic             err_q, err_d;
    logic             all_done_q, all_done_d;
    logic             total_clear_q, total_clear_d;

    logic             wr_en, opw_en, clear, load_err, rd_op;
    logic [RW-1:0]    rows;
    logic [CW-1:0]    cols, op_cnt, col_next;
    logic [RIW-1:0]   rd_row;
    logic [CIW-1:0]   rd_col;
    logic [DW-1:0]    rd_num;

    assign wr_en    = wr_valid & wr_ready;
    assign opw_en   = opw_valid & wr_ready;
    assign col_next = col_idx_q + 1'b1;

    worksheet_buffer #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS),
        .DW       (DW)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_num   (wr_num),
        .wr_eol   (wr_eol),
        .opw_en   (opw_en),
        .opw_op   (opw_op),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_num   (rd_num),
        .rd_op    (rd_op),
        .rows     (rows),
        .cols     (cols),
        .op_cnt   (op_cnt),
        .load_err (load_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            grand_total_q <= '0;
            err_q         <= 1'b0;
            all_done_q    <= 1'b0;
            total_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            grand_total_q <= grand_total_d;
            err_q         <= err_d;
            all_done_q    <= all_done_d;
            total_clear_q <= total_clear_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        grand_total_d = grand_total_q;
        err_d         = err_q | load_err;
        all_done_d    = 1'b0;
        total_clear_d = total_clear_q;
        clear         = 1'b0;
        // The previous sweep's total survives until the next worksheet begins loading.
        if (wr_en && total_clear_q) begin
            grand_total_d = '0;
            total_clear_d = 1'b0;
        end
        if (result_valid && state_q != WAIT_RES) begin
            err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rows == '0 || op_cnt != cols || err_q) begin
                        err_d = 1'b1;
                    end else begin
                        col_idx_d = '0;
                        row_idx_d = '0;
                        state_d   = FIRST_STATE;
                    end
                end
            end
            EMIT_OP: state_d = EMIT_NUM;
            EMIT_NUM: begin
                if (row_idx_q + 1'b1 == rows) begin
                    row_idx_d = '0;
                    state_d   = EMIT_DONE;
                end else begin
                    row_idx_d = row_idx_q + 1'b1;
                end
            end
            EMIT_DONE: state_d = WAIT_RES;
            WAIT_RES: begin
                if (result_valid) begin
                    grand_total_d = grand_total_q + result;
                    if (col_next == cols) begin
                        state_d       = IDLE;
                        col_idx_d     = '0;
                        all_done_d    = 1'b1;
                        total_clear_d = 1'b1;
                        clear         = 1'b1;
                    end else begin
                        col_idx_d = col_next;
`ifdef COL_DRIVER_OVERLAP_EN
                        if (rows == RW'(1)) begin
                            state_d = EMIT_DONE;
                        end else begin
                            row_idx_d = RW'(1);
                            state_d   = EMIT_NUM;
                        end
`else
                        state_d = EMIT_OP;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        num_valid = 1'b0;
        op_valid  = 1'b0;
        done      = 1'b0;
        rd_row    = row_idx_q[RIW-1:0];
        rd_col    = col_idx_q[CIW-1:0];
        case (state_q)
            EMIT_OP:  op_valid = 1'b1;
            EMIT_NUM: begin
                num_valid = 1'b1;
`ifdef COL_DRIVER_OVERLAP_EN
                op_valid  = (row_idx_q == '0);
`endif
            end
            EMIT_DONE: done = 1'b1;
            WAIT_RES: begin
`ifdef COL_DRIVER_OVERLAP_EN
                // Launch the next column in the same cycle its predecessor's result lands.
                if (result_valid && col_next != cols) begin
                    num_valid = 1'b1;
                    op_valid  = 1'b1;
                    rd_col    = col_next[CIW-1:0];
                end
`endif
            end
            default: ;
        endcase
    end

    assign num_in      = num_valid ? rd_num : '0;
    assign op_in       = op_valid ? rd_op : 1'b0;
    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign grand_total = grand_total_q;
    assign all_done    = all_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_column_stream_driver.sv
// Directed and randomized bench for column_stream_driver with a worksheet/reducer
// model; expects the default sequential build (COL_DRIVER_OVERLAP_EN undefined).
module tb_column_stream_driver;
    import column_stream_driver_pkg::*;

    localparam int MAX_ROWS = 8;
    localparam int MAX_COLS = 16;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst, wr_valid, wr_ready, wr_eol, opw_valid, opw_op, start;
    logic             num_valid, op_valid, op_in, done, result_valid, busy, all_done, err;
    logic [DW-1:0]    wr_num, num_in;
    logic [RES_W-1:0] result, grand_total;

    int compared = 0;
    int mismatched = 0;

    int unsigned     ws_num [MAX_ROWS][MAX_COLS];
    logic            ws_op [MAX_COLS];
    int              ws_rows, ws_cols;
    longint unsigned exp_total;

    always #5 clk = ~clk;

    column_stream_driver #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS),
        .DW       (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_num       (wr_num),
        .wr_eol       (wr_eol),
        .opw_valid    (opw_valid),
        .opw_op       (opw_op),
        .start        (start),
        .num_valid    (num_valid),
        .num_in       (num_in),
        .op_valid     (op_valid),
        .op_in        (op_in),
        .done         (done),
        .result_valid (result_valid),
        .result       (result),
        .grand_total  (grand_total),
        .busy         (busy),
        .all_done     (all_done),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic writeNum(input int unsigned n, input logic eol);
        wr_valid = 1'b1;
        wr_num   = n;
        wr_eol   = eol;
        tick();
        wr_valid = 1'b0;
        wr_eol   = 1'b0;
    endtask

    task automatic writeOp(input logic op);
        opw_valid = 1'b1;
        opw_op    = op;
        tick();
        opw_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Loads the model worksheet row-major, then the first nops operators.
    task automatic applyStimulus(input int nops);
        for (int r = 0; r < ws_rows; r++)
            for (int c = 0; c < ws_cols; c++)
                writeNum(ws_num[r][c], c == ws_cols - 1);
        for (int k = 0; k < nops; k++)
            writeOp(ws_op[k]);
        exp_total = 0;
        checkOutput("grand_total cleared by load", grand_total, exp_total);
    endtask

    function automatic longint unsigned colResult(input int c);
        longint unsigned acc = longint'(ws_num[0][c]);
        for (int r = 1; r < ws_rows; r++)
            acc = (ws_op[c] == OP_MUL) ? acc * ws_num[r][c] : acc + ws_num[r][c];
        return acc;
    endfunction

    // Starts a sweep and follows the expected strobe trace, acting as reducer.
    task automatic runSweep(input int stall);
        longint unsigned res;
        pulseStart();
        for (int c = 0; c < ws_cols; c++) begin
            checkOutput($sformatf("c%0d op_valid", c), op_valid, 1);
            checkOutput($sformatf("c%0d op_in", c), op_in, ws_op[c]);
            checkOutput($sformatf("c%0d quiet during op", c), {num_valid, done}, 0);
            tick();
            for (int r = 0; r < ws_rows; r++) begin
                checkOutput($sformatf("c%0d r%0d num_valid", c, r), num_valid, 1);
                checkOutput($sformatf("c%0d r%0d num_in", c, r), num_in, ws_num[r][c]);
                checkOutput($sformatf("c%0d r%0d quiet", c, r), {op_valid, done}, 0);
                tick();
            end
            checkOutput($sformatf("c%0d done", c), done, 1);
            checkOutput($sformatf("c%0d quiet at done", c), {num_valid, op_valid}, 0);
            tick();
            for (int s = 0; s < stall; s++) begin
                checkOutput($sformatf("c%0d stall%0d strobes", c, s), {num_valid, op_valid, done}, 0);
                checkOutput($sformatf("c%0d stall%0d busy", c, s), busy, 1);
                tick();
            end
            res = colResult(c);
            result_valid = 1'b1;
            result = res;
            tick();
            result_valid = 1'b0;
            result = 64'($urandom());
            exp_total += res;
            checkOutput($sformatf("c%0d running total", c), grand_total, exp_total);
        end
        checkOutput("all_done pulse", all_done, 1);
        checkOutput("idle after sweep", {busy, wr_ready}, 2'b01);
        checkOutput("no err after sweep", err, 0);
        tick();
        checkOutput("all_done one cycle", all_done, 0);
        checkOutput("grand_total holds", grand_total, exp_total);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_num = '0; wr_eol = 1'b0; opw_valid = 1'b0;
        opw_op = 1'b0; start = 1'b0; result_valid = 1'b0; result = '0;
        tick();
        tick();
        checkOutput("reset strobes", {num_valid, op_valid, done, all_done, busy, err}, 0);
        checkOutput("reset wr_ready", wr_ready, 1);
        checkOutput("reset grand_total", grand_total, 0);
        checkOutput("reset num/op", {num_in, op_in}, 0);
        rst = 1'b0;
        tick();

        $display("[TB] worksheet from test plan");
        ws_rows = 3; ws_cols = 4;
        ws_num[0][0] = 123; ws_num[0][1] = 328; ws_num[0][2] = 51;  ws_num[0][3] = 64;
        ws_num[1][0] = 45;  ws_num[1][1] = 64;  ws_num[1][2] = 387; ws_num[1][3] = 23;
        ws_num[2][0] = 6;   ws_num[2][1] = 98;  ws_num[2][2] = 215; ws_num[2][3] = 314;
        ws_op[0] = OP_MUL; ws_op[1] = OP_ADD; ws_op[2] = OP_MUL; ws_op[3] = OP_ADD;
        applyStimulus(4);
        checkOutput("plan load err", err, 0);
        runSweep(0);
        checkOutput("plan grand_total", grand_total, 64'd4277556);

        $display("[TB] single cell worksheet");
        ws_rows = 1; ws_cols = 1; ws_num[0][0] = 7; ws_op[0] = OP_ADD;
        applyStimulus(1);
        runSweep(0);
        checkOutput("single grand_total", grand_total, 64'd7);

        $display("[TB] ragged row");
        for (int c = 0; c < 4; c++) writeNum(c + 1, c == 3);
        for (int c = 0; c < 3; c++) writeNum(c + 10, c == 2);
        checkOutput("ragged err", err, 1);
        pulseStart();
        checkOutput("ragged start ignored", {busy, num_valid, op_valid, done}, 0);
        tick();
        checkOutput("ragged still idle", {busy, num_valid, op_valid, done}, 0);
        doReset();

        $display("[TB] missing operator");
        ws_rows = 1; ws_cols = 4;
        for (int c = 0; c < 4; c++) begin ws_num[0][c] = $urandom_range(0, 99); ws_op[c] = 1'($urandom()); end
        applyStimulus(3);
        checkOutput("short ops no err yet", err, 0);
        pulseStart();
        checkOutput("short ops err", err, 1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("short ops quiet%0d", k), {busy, num_valid, op_valid, done}, 0);
            tick();
        end
        doReset();

        $display("[TB] reset during emission");
        ws_rows = 2; ws_cols = 1; ws_num[0][0] = 11; ws_num[1][0] = 22; ws_op[0] = OP_ADD;
        applyStimulus(1);
        pulseStart();
        tick();
        checkOutput("in EMIT_NUM", num_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort strobes", {num_valid, op_valid, done, all_done, busy, err}, 0);
        checkOutput("abort wr_ready", wr_ready, 1);
        checkOutput("abort grand_total", grand_total, 0);

        $display("[TB] stalled reducer and spurious result");
        ws_rows = 2; ws_cols = 3;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) ws_num[r][c] = $urandom_range(0, 500);
        for (int c = 0; c < 3; c++) ws_op[c] = 1'($urandom());
        applyStimulus(3);
        runSweep(10);
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        checkOutput("spurious result err", err, 1);
        checkOutput("spurious result total unchanged", grand_total, exp_total);
        tick();
        tick();
        checkOutput("err sticky", err, 1);
        doReset();

        $display("[TB] row overflow");
        for (int r = 0; r < MAX_ROWS; r++) writeNum(r, 1'b1);
        checkOutput("full rows no err", err, 0);
        writeNum(99, 1'b1);
        checkOutput("extra row err", err, 1);
        doReset();

        $display("[TB] randomized worksheets");
        for (int it = 0; it < 6; it++) begin
            ws_rows = (it == 0) ? MAX_ROWS : $urandom_range(1, MAX_ROWS);
            ws_cols = (it == 0) ? MAX_COLS : $urandom_range(1, 6);
            for (int r = 0; r < ws_rows; r++)
                for (int c = 0; c < ws_cols; c++)
                    ws_num[r][c] = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 999);
            for (int c = 0; c < ws_cols; c++) ws_op[c] = 1'($urandom());
            applyStimulus(ws_cols);
            runSweep($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
